// File: rtl/dmac_cfg_desc_slave_if.sv
// AHB-Lite slave-side bus bundle for the DMAC descriptor store.
// Latency: none; this file only groups wires.
// Backpressure: HReadyOut from the slave stretches the data phase; HReady carries the bus-level ready back in.
// Ports: HSel/HAddr/HTrans/HWrite/HSize/HWData/HReady flow master->slave, HRData/HReadyOut/HResp flow slave->master.
interface dmac_cfg_desc_slave_if #(
   parameter int ADDR_W = 32
);
   logic              HSel;
   logic [ADDR_W-1:0] HAddr;
   logic [1:0]        HTrans;
   logic              HWrite;
   logic [2:0]        HSize;
   logic [31:0]       HWData;
   logic              HReady;
   logic [31:0]       HRData;
   logic              HReadyOut;
   logic              HResp;

   modport master (
      output HSel, HAddr, HTrans, HWrite, HSize, HWData, HReady,
      input  HRData, HReadyOut, HResp
   );

   modport slave (
      input  HSel, HAddr, HTrans, HWrite, HSize, HWData, HReady,
      output HRData, HReadyOut, HResp
   );
endinterface

// File: rtl/dmac_cfg_desc_slave.sv
// AHB-Lite slave holding a 4-word DMA descriptor (SAddr, DAddr, TransSize, Ctrl) plus the DMA request handshake.
// Latency: WAIT_STATES data-phase wait cycles per transfer; errors take two data-phase cycles.
// Backpressure: HReadyOut low stretches the data phase; a new address phase is taken in the final data cycle.
// Ports: clk/rst (async, active-high); bus = AHB slave side; prog_we/prog_idx/prog_data = local descriptor
//        programming; start/req_ack/dmac_req = request handshake; busy = request pending; desc_done = Ctrl fetched.
module dmac_cfg_desc_slave #(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   dmac_cfg_desc_slave_if.slave  bus,
   input  logic                  prog_we,
   input  logic [1:0]            prog_idx,
   input  logic [31:0]           prog_data,
   input  logic                  start,
   input  logic                  req_ack,
   output logic                  dmac_req,
   output logic                  busy,
   output logic                  desc_done
);

   typedef enum logic [2:0] {
      B_IDLE,
      B_WAIT,
      B_DATA,
      B_ERR1,
      B_ERR2
   } bus_st_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_REQ,
      R_SERVE
   } req_st_t;

   localparam logic [2:0] WS = 3'(WAIT_STATES);

   bus_st_t     bus_st_q;
   req_st_t     req_st_q;
   logic [2:0]  cnt_q;
   logic [1:0]  idx_q;
   logic        wr_q;
   logic [31:0] hrdata_q;
   logic        hready_q;
   logic        hresp_q;
   logic        dmac_req_q;
   logic        busy_q;
   logic        desc_done_q;
   logic [31:0] desc_q [4];
   logic [31:0] desc_d [4];

   logic        lock;
   logic        ahb_wr;
   logic        rd_done;
   logic        accept;
   logic        addr_err;
   logic        unused_htrans0;

   // HTrans[0] only separates BUSY from IDLE and NONSEQ from SEQ; neither matters here.
   assign unused_htrans0 = bus.HTrans[0];

   assign lock    = (req_st_q != R_IDLE);
   assign ahb_wr  = (bus_st_q == B_DATA) && wr_q && !lock;
   assign rd_done = (bus_st_q == B_DATA) && !wr_q;

   // Address phases are only taken when the data phase is idle or in its last cycle.
   assign accept   = bus.HSel && bus.HReady && bus.HTrans[1]
                     && (bus_st_q != B_WAIT) && (bus_st_q != B_ERR1);
   assign addr_err = (bus.HAddr[ADDR_W-1:4] != BASE_ADDR[ADDR_W-1:4])
                     || (bus.HAddr[1:0] != 2'b00)
                     || (bus.HSize != 3'b010);

   // Next descriptor contents; the AHB write is applied last so it wins a same-word collision.
   always_comb begin
      for (int i = 0; i < 4; i++) desc_d[i] = desc_q[i];
      if (prog_we && !lock) desc_d[prog_idx] = prog_data;
      if (ahb_wr)           desc_d[idx_q]    = bus.HWData;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) desc_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) desc_q[i] <= desc_d[i];
      end
   end

   // Bus FSM. Read data is sampled from desc_d so a write committing on the same edge is forwarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_st_q <= B_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         hrdata_q <= '0;
         hready_q <= 1'b1;
         hresp_q  <= 1'b0;
      end else begin
         case (bus_st_q)
            B_WAIT: begin
               if (cnt_q <= 3'd1) begin
                  bus_st_q <= B_DATA;
                  hready_q <= 1'b1;
                  if (!wr_q) hrdata_q <= desc_d[idx_q];
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            B_ERR1: begin
               bus_st_q <= B_ERR2;
               hready_q <= 1'b1;
               hresp_q  <= 1'b1;
            end
            default: begin
               if (accept) begin
                  idx_q <= bus.HAddr[3:2];
                  wr_q  <= bus.HWrite;
                  if (addr_err) begin
                     bus_st_q <= B_ERR1;
                     hready_q <= 1'b0;
                     hresp_q  <= 1'b1;
                  end else if (WS == 3'd0) begin
                     bus_st_q <= B_DATA;
                     hready_q <= 1'b1;
                     hresp_q  <= 1'b0;
                     if (!bus.HWrite) hrdata_q <= desc_d[bus.HAddr[3:2]];
                  end else begin
                     bus_st_q <= B_WAIT;
                     cnt_q    <= WS;
                     hready_q <= 1'b0;
                     hresp_q  <= 1'b0;
                  end
               end else begin
                  bus_st_q <= B_IDLE;
                  hready_q <= 1'b1;
                  hresp_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   // Request FSM: a completed Ctrl-word read while serving closes out the request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_st_q    <= R_IDLE;
         dmac_req_q  <= 1'b0;
         busy_q      <= 1'b0;
         desc_done_q <= 1'b0;
      end else begin
         desc_done_q <= 1'b0;
         case (req_st_q)
            R_IDLE: begin
               if (start) begin
                  req_st_q   <= R_REQ;
                  dmac_req_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            R_REQ: begin
               if (req_ack) begin
                  req_st_q   <= R_SERVE;
                  dmac_req_q <= 1'b0;
               end
            end
            R_SERVE: begin
               if (rd_done && (idx_q == 2'd3)) begin
                  req_st_q    <= R_IDLE;
                  busy_q      <= 1'b0;
                  desc_done_q <= 1'b1;
               end
            end
            default: begin
               req_st_q   <= R_IDLE;
               dmac_req_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.HRData    = hrdata_q;
   assign bus.HReadyOut = hready_q;
   assign bus.HResp     = hresp_q;
   assign dmac_req      = dmac_req_q;
   assign busy          = busy_q;
   assign desc_done     = desc_done_q;

endmodule

// File: tb/tb_dmac_cfg_desc_slave.sv
// Directed bench for dmac_cfg_desc_slave: table of AHB transfers with expected wait/response/data,
// plus hand sequences for the request handshake, pipelined transfers and reset during a wait state.
// Runs with WAIT_STATES=1 and a non-zero descriptor window base.
module tb_dmac_cfg_desc_slave;
   localparam int          ADDR_W = 32;
   localparam logic [31:0] BASE   = 32'h4000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        prog_we;
   logic [1:0]  prog_idx;
   logic [31:0] prog_data;
   logic        start;
   logic        req_ack;
   logic        dmac_req;
   logic        busy;
   logic        desc_done;

   int n_vec  = 0;
   int n_miss = 0;
   int dd_cnt = 0;

   always #5 clk = ~clk;

   dmac_cfg_desc_slave_if #(.ADDR_W(ADDR_W)) bus ();
   assign bus.HReady = bus.HReadyOut;

   dmac_cfg_desc_slave #(
      .ADDR_W(ADDR_W),
      .BASE_ADDR(BASE),
      .WAIT_STATES(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .prog_we(prog_we),
      .prog_idx(prog_idx),
      .prog_data(prog_data),
      .start(start),
      .req_ack(req_ack),
      .dmac_req(dmac_req),
      .busy(busy),
      .desc_done(desc_done)
   );

   always @(negedge clk) if (desc_done === 1'b1) dd_cnt++;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic        prog_same;
      int          exp_waits;
      logic        exp_err;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata, input logic ps, input int w,
                               input logic err, input logic chk, input logic [31:0] rd);
      vec_t v;
      v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata; v.prog_same = ps;
      v.exp_waits = w; v.exp_err = err; v.chk_rd = chk; v.exp_rd = rd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic prog(input logic [1:0] idx, input logic [31:0] data);
      prog_we = 1'b1; prog_idx = idx; prog_data = data;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   // One non-pipelined transfer; entered and left #1 after a rising edge with the bus idle.
   task automatic ahb(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic prog_same,
                      output int waits, output logic resp_first, output logic resp_last,
                      output logic [31:0] rdata);
      int guard;
      logic [31:0] a;
      a = addr;
      bus.HSel = 1'b1; bus.HTrans = 2'b10; bus.HAddr = addr; bus.HWrite = wr; bus.HSize = size;
      @(posedge clk); #1;
      bus.HSel = 1'b0; bus.HTrans = 2'b00; bus.HWData = wdata;
      waits = 0; guard = 0; resp_first = bus.HResp;
      while (bus.HReadyOut !== 1'b1 && guard < 20) begin
         waits++; guard++;
         @(posedge clk); #1;
      end
      if (guard >= 20) begin
         n_vec++; n_miss++;
         $display("FAIL ahb_timeout: HReadyOut %b after %0d cycles, required 1", bus.HReadyOut, guard);
      end
      resp_last = bus.HResp;
      rdata     = bus.HRData;
      if (prog_same) begin
         prog_we = 1'b1; prog_idx = a[3:2]; prog_data = 32'h7777_7777;
      end
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      int w; logic rf, rl; logic [31:0] rd; logic ok;
      for (int i = lo; i <= hi; i++) begin
         ahb(vt[i].wr, vt[i].addr, vt[i].size, vt[i].wdata, vt[i].prog_same, w, rf, rl, rd);
         ok = (w == vt[i].exp_waits) && (rf === vt[i].exp_err) && (rl === vt[i].exp_err)
              && (!vt[i].chk_rd || rd === vt[i].exp_rd);
         n_vec++;
         if (!ok) begin
            n_miss++;
            $display("FAIL vec%0d: waits=%0d resp=%b/%b rdata=%h, required waits=%0d resp=%b/%b rdata=%h",
                     i, w, rf, rl, rd, vt[i].exp_waits, vt[i].exp_err, vt[i].exp_err, vt[i].exp_rd);
         end
      end
   endtask

   initial begin
      // Phase A: idle-state reads, errors, untouched registers (0..9)
      vt.push_back(mk(0, BASE+32'h0,   3'b010, 0, 0, 1, 0, 1, 32'h1000));
      vt.push_back(mk(0, BASE+32'h4,   3'b010, 0, 0, 1, 0, 1, 32'h2000));
      vt.push_back(mk(0, BASE+32'h8,   3'b010, 0, 0, 1, 0, 1, 32'h8));
      vt.push_back(mk(0, BASE+32'hC,   3'b010, 0, 0, 1, 0, 1, 32'h3));
      vt.push_back(mk(0, BASE+32'h10,  3'b010, 0, 0, 1, 1, 0, 32'h0));
      vt.push_back(mk(0, BASE+32'h4,   3'b000, 0, 0, 1, 1, 0, 32'h0));
      vt.push_back(mk(1, BASE+32'h8,   3'b000, 32'hFFFF, 0, 1, 1, 0, 32'h0));
      vt.push_back(mk(0, BASE+32'h9,   3'b010, 0, 0, 1, 1, 0, 32'h0));
      vt.push_back(mk(0, BASE+32'h8,   3'b010, 0, 0, 1, 0, 1, 32'h8));
      vt.push_back(mk(0, BASE+32'h104, 3'b010, 0, 0, 1, 1, 0, 32'h0));
      // Phase B: locked while serving (10..14)
      vt.push_back(mk(1, BASE+32'h4,   3'b010, 32'hDEAD, 0, 1, 0, 0, 32'h0));
      vt.push_back(mk(0, BASE+32'h4,   3'b010, 0, 0, 1, 0, 1, 32'h2000));
      vt.push_back(mk(0, BASE+32'h0,   3'b010, 0, 0, 1, 0, 1, 32'h1000));
      vt.push_back(mk(0, BASE+32'h8,   3'b010, 0, 0, 1, 0, 1, 32'h8));
      vt.push_back(mk(0, BASE+32'hC,   3'b010, 0, 0, 1, 0, 1, 32'h3));
      // Phase C: unlocked write, AHB beats same-cycle prog_we (15..16)
      vt.push_back(mk(1, BASE+32'h4,   3'b010, 32'hDEAD, 1, 1, 0, 0, 32'h0));
      vt.push_back(mk(0, BASE+32'h4,   3'b010, 0, 0, 1, 0, 1, 32'hDEAD));
      // Phase D: everything cleared by reset (17..20)
      vt.push_back(mk(0, BASE+32'h0,   3'b010, 0, 0, 1, 0, 1, 32'h0));
      vt.push_back(mk(0, BASE+32'h4,   3'b010, 0, 0, 1, 0, 1, 32'h0));
      vt.push_back(mk(0, BASE+32'h8,   3'b010, 0, 0, 1, 0, 1, 32'h0));
      vt.push_back(mk(0, BASE+32'hC,   3'b010, 0, 0, 1, 0, 1, 32'h0));

      rst = 1'b1; prog_we = 1'b0; prog_idx = '0; prog_data = '0; start = 1'b0; req_ack = 1'b0;
      bus.HSel = 1'b0; bus.HAddr = '0; bus.HTrans = 2'b00; bus.HWrite = 1'b0;
      bus.HSize = 3'b010; bus.HWData = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hreadyout", 32'(bus.HReadyOut), 32'h1);
      check("rst_hresp",     32'(bus.HResp),     32'h0);
      check("rst_dmac_req",  32'(dmac_req),      32'h0);
      check("rst_busy",      32'(busy),          32'h0);
      check("rst_desc_done", 32'(desc_done),     32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      prog(2'd0, 32'h1000);
      prog(2'd1, 32'h2000);
      prog(2'd2, 32'h8);
      prog(2'd3, 32'h3);

      run_vecs(0, 9);
      @(posedge clk); #1;
      check("idle_idx3_no_done", 32'(dd_cnt), 32'h0);

      // req_ack while idle must not start anything
      req_ack = 1'b1; @(posedge clk); #1; req_ack = 1'b0;
      check("stray_ack_busy", 32'(busy), 32'h0);

      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      check("start_dmac_req", 32'(dmac_req), 32'h1);
      check("start_busy",     32'(busy),     32'h1);
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      check("restart_dmac_req", 32'(dmac_req), 32'h1);
      req_ack = 1'b1; @(posedge clk); #1; req_ack = 1'b0;
      check("ack_dmac_req", 32'(dmac_req), 32'h0);
      check("ack_busy",     32'(busy),     32'h1);

      prog(2'd1, 32'h5555);
      run_vecs(10, 13);
      check("serve_busy_held", 32'(busy), 32'h1);
      run_vecs(14, 14);
      check("ctrl_desc_done", 32'(desc_done), 32'h1);
      check("ctrl_busy",      32'(busy),      32'h0);
      @(posedge clk); #1;
      check("desc_done_pulse", 32'(desc_done), 32'h0);
      check("desc_done_count", 32'(dd_cnt),    32'h1);

      run_vecs(15, 16);

      // Back-to-back reads: second address phase taken in the first data cycle
      bus.HSel = 1'b1; bus.HTrans = 2'b10; bus.HAddr = BASE; bus.HWrite = 1'b0; bus.HSize = 3'b010;
      @(posedge clk); #1;
      check("pipe_wait1", 32'(bus.HReadyOut), 32'h0);
      bus.HAddr = BASE + 32'h4;
      @(posedge clk); #1;
      check("pipe_data1_rdy", 32'(bus.HReadyOut), 32'h1);
      check("pipe_data1",     bus.HRData,         32'h1000);
      @(posedge clk); #1;
      bus.HSel = 1'b0; bus.HTrans = 2'b00;
      check("pipe_wait2", 32'(bus.HReadyOut), 32'h0);
      @(posedge clk); #1;
      check("pipe_data2_rdy", 32'(bus.HReadyOut), 32'h1);
      check("pipe_data2",     bus.HRData,         32'hDEAD);
      @(posedge clk); #1;

      // Reset in the middle of a wait state
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      check("pre_rst_dmac_req", 32'(dmac_req), 32'h1);
      bus.HSel = 1'b1; bus.HTrans = 2'b10; bus.HAddr = BASE; bus.HWrite = 1'b0;
      @(posedge clk); #1;
      bus.HSel = 1'b0; bus.HTrans = 2'b00;
      check("pre_rst_wait", 32'(bus.HReadyOut), 32'h0);
      rst = 1'b1; #1;
      check("mid_rst_hreadyout", 32'(bus.HReadyOut), 32'h1);
      check("mid_rst_hresp",     32'(bus.HResp),     32'h0);
      check("mid_rst_dmac_req",  32'(dmac_req),      32'h0);
      check("mid_rst_busy",      32'(busy),          32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_vecs(17, 20);
      @(posedge clk); #1;
      check("final_done_count", 32'(dd_cnt), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
